// File: rtl/i_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and presents fetched words to decode.
// Optional IFETCH_PERF_EN adds a saturating fetch_count output of consumed instructions.
module i_fetch #(
  parameter int unsigned           AW        = 8,
  parameter int unsigned           DW        = 16,
  parameter logic [AW-1:0]         RESET_PC  = '0,
  parameter logic [DW-1:0]         HALT_WORD = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]   fetch_count
`endif
);

  typedef enum logic {RUN, HALT} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_pc_q;
  logic          req_valid_q;
  logic          take;
  logic          running;

  assign running     = (state_q == RUN);
  assign instr_valid = req_valid_q & ~redirect_valid & running;
  assign take        = instr_valid & ~stall;
  assign instr       = rom_q;
  assign instr_pc    = req_pc_q;
  assign halted      = (state_q == HALT);

  // While stalled the ROM is re-addressed with the presented word so rom_q stays stable.
  always_comb begin
    rom_addr = pc_q;
    if (redirect_valid)
      rom_addr = redirect_addr;
    else if (running && req_valid_q && stall)
      rom_addr = req_pc_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q     <= RUN;
      req_pc_q    <= redirect_addr;
      req_valid_q <= 1'b1;
      pc_q        <= redirect_addr + 1'b1;
    end else if (state_q == HALT) begin
      req_valid_q <= 1'b0;
    end else if (take && (instr == HALT_WORD)) begin
      state_q     <= HALT;
      req_valid_q <= 1'b0;
    end else if (req_valid_q && stall) begin
      req_valid_q <= req_valid_q;
    end else begin
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
      pc_q        <= pc_q + 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_count_q;
  logic [15:0] fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (take && (fetch_count_q != '1))
      fetch_count_d = fetch_count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fetch_count_q <= '0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch with a registered ROM model and hand-computed expectations.
module tb_i_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_q = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  i_fetch #(.AW(8), .DW(16), .RESET_PC(8'h00), .HALT_WORD(16'h0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [7:0] pc, input logic [15:0] w);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    check({tag, "_instr"}, 32'(instr), 32'(w));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h00] = 16'hC30A; mem[8'h01] = 16'hC4F2; mem[8'h02] = 16'hC515;
    mem[8'h03] = 16'hC61C; mem[8'h04] = 16'hC740; mem[8'h05] = 16'hC8A1;
    mem[8'h06] = 16'hC964; mem[8'h0B] = 16'h1840; mem[8'h0C] = 16'h990F;
    mem[8'h0D] = 16'h7777; mem[8'h0E] = 16'h0000; mem[8'hFF] = 16'h5AFF;

    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'h00);
    @(negedge clock);
    reset = 1'b0;

    // straight line
    cyc(); chk_word("s0", 8'h00, 16'hC30A);
    cyc(); chk_word("s1", 8'h01, 16'hC4F2);
    cyc(); chk_word("s2", 8'h02, 16'hC515);
    cyc(); chk_word("s3", 8'h03, 16'hC61C);

    // stall three cycles on 03
    stall = 1'b1; #1;
    check("stall_addr0", 32'(rom_addr), 32'h03);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_word("stall_hold", 8'h03, 16'hC61C);
      check("stall_addr", 32'(rom_addr), 32'h03);
    end
    stall = 1'b0; #1;
    check("unstall_addr", 32'(rom_addr), 32'h04);
    cyc(); chk_word("s4", 8'h04, 16'hC740);
    cyc(); chk_word("s5", 8'h05, 16'hC8A1);
    cyc(); chk_word("s6", 8'h06, 16'hC964);

    // redirect to 0B drops 06
    redirect_valid = 1'b1; redirect_addr = 8'h0B; #1;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr", 32'(rom_addr), 32'h0B);
    cyc(); redirect_valid = 1'b0; #1;
    chk_word("r0B", 8'h0B, 16'h1840);
    cyc(); chk_word("r0C", 8'h0C, 16'h990F);
    cyc(); chk_word("r0D", 8'h0D, 16'h7777);
    cyc(); chk_word("r0E", 8'h0E, 16'h0000);
    check("pre_halt", 32'(halted), 32'd0);

    // halt
    cyc();
    check("halt_h", 32'(halted), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_addr", 32'(rom_addr), 32'h0F);
`ifdef IFETCH_PERF_EN
    check("perf_count", 32'(fetch_count), 32'd10);
`endif
    stall = 1'b1;
    cyc();
    check("halt_h2", 32'(halted), 32'd1);
    check("halt_addr2", 32'(rom_addr), 32'h0F);
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 8'h00; #1;
    check("hredir_addr", 32'(rom_addr), 32'h00);
    cyc(); redirect_valid = 1'b0; #1;
    check("resume_h", 32'(halted), 32'd0);
    chk_word("resume", 8'h00, 16'hC30A);

    // wrap: redirect to FF
    redirect_valid = 1'b1; redirect_addr = 8'hFF; #1;
    check("wredir_valid", 32'(instr_valid), 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    chk_word("wFF", 8'hFF, 16'h5AFF);
    cyc(); chk_word("w00", 8'h00, 16'hC30A);
    cyc(); chk_word("w01", 8'h01, 16'hC4F2);

    // async reset between edges
    @(negedge clock);
    reset = 1'b1; #1;
    check("areset_valid", 32'(instr_valid), 32'd0);
    check("areset_addr", 32'(rom_addr), 32'h00);
    check("areset_pc", 32'(instr_pc), 32'h00);
`ifdef IFETCH_PERF_EN
    check("areset_count", 32'(fetch_count), 32'd0);
`endif

    // stall while nothing is valid is ignored
    stall = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    cyc(); chk_word("idle_stall", 8'h00, 16'hC30A);
    check("idle_stall_addr", 32'(rom_addr), 32'h00);
    stall = 1'b0;
    cyc(); chk_word("post_idle", 8'h01, 16'hC4F2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
